elbeth_ex_mem_register: RTL
===========================

// Module: elbeth_ex_mem_register
// PURPOSE
//   EX->MEM pipeline register, directly downstream of the ALU. Captures alu_result plus store data
//   and memory/writeback control. Provides a valid/ready handshake with a 2-entry skid buffer so
//   MEM-stage backpressure never drops an EX result. Exports the head entry to the forwarding unit
//   and flags misaligned load/store addresses.
// PARAMETERS
//   DATA_WIDTH      32  width of alu_result, store data and forwarded data
//   REG_ADDR_WIDTH  5   register-file address width
// PORTS
//   clk               in   1       clock; all state updates on rising edge
//   rst               in   1       synchronous, active-high reset
//   ex_valid          in   1       EX presents a valid instruction
//   ex_ready          out  1       register can accept an EX instruction this cycle
//   ex_alu_result     in   32      ALU result (effective address for loads/stores)
//   ex_store_data     in   32      rs2 value for stores
//   ex_rd_addr        in   5       destination register
//   ex_rd_we          in   1       writeback enable
//   ex_mem_read       in   1       instruction is a load
//   ex_mem_write      in   1       instruction is a store
//   ex_mem_size       in   2       00 byte, 01 half, 10 word, 11 reserved
//   ex_mem_unsigned   in   1       zero-extend load (LBU/LHU)
//   flush             in   1       kill all held and incoming instructions
//   mem_valid         out  1       head entry valid toward MEM
//   mem_ready         in   1       MEM accepts head entry this cycle
//   mem_alu_result    out  32      head alu_result
//   mem_store_data    out  32      head store data
//   mem_rd_addr       out  5       head rd
//   mem_rd_we         out  1       head writeback enable
//   mem_mem_read      out  1       head load flag
//   mem_mem_write     out  1       head store flag
//   mem_mem_size      out  2       head access size
//   mem_mem_unsigned  out  1       head unsigned-load flag
//   mem_misaligned    out  1       head is a load/store with misaligned address
//   fwd_valid         out  1       mem_valid & mem_rd_we (forwarding candidate)
//   fwd_rd_addr       out  5       = mem_rd_addr
//   fwd_data          out  32      = mem_alu_result
// BEHAVIOUR
//   - Storage: head register H and skid register S. States: EMPTY, ONE (H full), TWO (H+S full).
//   - ex_ready = (state != TWO), registered and valid from reset; no combinational path from
//     mem_ready. Accept = ex_valid & ex_ready. Retire = mem_valid & mem_ready.
//   - EMPTY: accept -> ONE, H <= input.
//   - ONE:   accept & retire -> ONE, H <= input.  accept & !retire -> TWO, S <= input.
//            !accept & retire -> EMPTY.  Neither -> hold.
//   - TWO:   retire -> ONE, H <= S.  No accept possible (ex_ready = 0).
//   - Order strictly FIFO; every accepted, unflushed instruction retires exactly once.
//   - Latency: accepted in cycle N -> visible on mem_* in cycle N+1 when H was empty or retiring.
//   - Held outputs stable while mem_valid & !mem_ready.
//   - rd_addr == 0 forces stored rd_we = 0 (x0 never written or forwarded).
//   - mem_misaligned (combinational from H): (mem_read|mem_write) & ((size==01 & addr[0]) |
//     (size==10 & addr[1:0]!=0)). Size 11 with read/write also sets mem_misaligned.
//   - Data is captured unmodified; no width conversion.
//   - flush: next state EMPTY, H and S invalid, input that cycle not captured; retire in the
//     flush cycle still counts for MEM. flush has priority over accept.
//   - Reset: state EMPTY, ex_ready = 1, mem_valid = 0, all mem_* / fwd_* outputs = 0.
//     Reset mid-operation discards both entries exactly like flush.
//   - Output data while mem_valid = 0 holds last value or 0; mem_valid is the only qualifier.
// TESTING
//   1. Reset, mem_ready=1, ex_valid with result 0x0000_1234, rd=5, rd_we=1 -> next cycle
//      mem_valid=1, mem_alu_result=0x1234, fwd_valid=1, fwd_rd_addr=5.
//   2. mem_ready=0, three back-to-back ex_valid (A,B,C) -> A in H, B in S, ex_ready=0 on cycle 3,
//      C held upstream; release mem_ready -> A,B,C retire in order, no loss or duplication.
//   3. Word load at 0x0000_1002 -> mem_misaligned=1. Half store at 0x1002 -> 0. Byte load at
//      0x1003 -> 0.
//   4. ex_rd_addr=0, ex_rd_we=1 -> mem_rd_we=0, fwd_valid=0.
//   5. State TWO, assert flush together with ex_valid -> next cycle mem_valid=0, ex_ready=1.
//      Then a new instruction passes normally.
//   6. Random valid/ready/flush, 10k cycles, scoreboard vs reference FIFO model -> order,
//      content and count match; assert outputs stable while stalled.

Source files
------------

// File: rtl/elbeth_ex_mem_register.sv
// -----------------------------------------------------------------------------
// elbeth_ex_mem_register
//   EX->MEM pipeline register sitting directly after the ALU. Holds the ALU
//   result, store data and memory/writeback control for one instruction in a
//   head register (H), backed by a skid register (S). MEM can stall without
//   dropping an EX result. The head entry is also exported to the forwarding
//   unit, and misaligned load/store addresses are flagged.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   ex_valid / ex_ready  upstream handshake (ex_ready is a flop output)
//   ex_*                 instruction fields from EX
//   flush                discard held and incoming instructions
//   mem_valid/mem_ready  downstream handshake
//   mem_*                head entry fields toward MEM
//   mem_misaligned       head is a load/store with a misaligned address
//   fwd_valid/_rd_addr/_data  forwarding view of the head entry
// -----------------------------------------------------------------------------
module elbeth_ex_mem_register #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_rd_we,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [1:0]                ex_mem_size,
  input  logic                      ex_mem_unsigned,
  input  logic                      flush,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [DATA_WIDTH-1:0]     mem_alu_result,
  output logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                      mem_rd_we,
  output logic                      mem_mem_read,
  output logic                      mem_mem_write,
  output logic [1:0]                mem_mem_size,
  output logic                      mem_mem_unsigned,
  output logic                      mem_misaligned,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
    logic                      mem_read;
    logic                      mem_write;
    logic [1:0]                mem_size;
    logic                      mem_unsigned;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t h_q, s_q, in_entry;
  logic   ex_ready_q;
  logic   accept, retire;
  logic   load_h_in, load_h_skid, load_s_in;

  // x0 is never a writeback or forwarding target.
  always_comb begin
    in_entry.alu_result   = ex_alu_result;
    in_entry.store_data   = ex_store_data;
    in_entry.rd_addr      = ex_rd_addr;
    in_entry.rd_we        = ex_rd_we & (ex_rd_addr != '0);
    in_entry.mem_read     = ex_mem_read;
    in_entry.mem_write    = ex_mem_write;
    in_entry.mem_size     = ex_mem_size;
    in_entry.mem_unsigned = ex_mem_unsigned;
  end

  assign mem_valid = (state_q != EMPTY);
  assign ex_ready  = ex_ready_q;
  assign accept    = ex_valid & ex_ready_q;
  assign retire    = mem_valid & mem_ready;

  always_comb begin
    state_d     = state_q;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s_in   = 1'b0;
    if (flush) begin
      // Retire in this cycle still completes in MEM; everything else is dropped.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_h_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && retire) begin
            load_h_in = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_s_in = 1'b1;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            state_d     = ONE;
            load_h_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      ex_ready_q <= 1'b1;
      h_q        <= '0;
      s_q        <= '0;
    end else begin
      state_q    <= state_d;
      // Registered copy of (state != TWO) so ex_ready has no path from mem_ready.
      ex_ready_q <= (state_d != TWO);
      if (load_h_in)
        h_q <= in_entry;
      else if (load_h_skid)
        h_q <= s_q;
      if (load_s_in)
        s_q <= in_entry;
    end
  end

  assign mem_alu_result   = h_q.alu_result;
  assign mem_store_data   = h_q.store_data;
  assign mem_rd_addr      = h_q.rd_addr;
  assign mem_rd_we        = h_q.rd_we;
  assign mem_mem_read     = h_q.mem_read;
  assign mem_mem_write    = h_q.mem_write;
  assign mem_mem_size     = h_q.mem_size;
  assign mem_mem_unsigned = h_q.mem_unsigned;

  // Reserved size 11 on a memory access is reported as misaligned.
  assign mem_misaligned = (h_q.mem_read | h_q.mem_write) &
                          (((h_q.mem_size == 2'b01) & h_q.alu_result[0]) |
                           ((h_q.mem_size == 2'b10) & (h_q.alu_result[1:0] != 2'b00)) |
                           (h_q.mem_size == 2'b11));

  assign fwd_valid   = mem_valid & h_q.rd_we;
  assign fwd_rd_addr = h_q.rd_addr;
  assign fwd_data    = h_q.alu_result;

endmodule
